i_mem_loader: RTL

- Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake and assembles 32-bit words.
- Issues one-cycle word writes to the instruction memory write port at word-aligned byte addresses (0, 4, 8, …). These are the same byte addresses the fetch side later presents and shifts right by 2.
- Holds the CPU in reset (cpu_hold) for the whole load.
- Sits between the host/UART byte source and the instruction memory.

---
 rtl/i_mem_loader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/i_mem_loader.sv
// Instruction memory writer: assembles a big-endian byte stream into 32-bit words
// and writes them at word-aligned byte addresses while holding the CPU in reset.
//
// state   | meaning
// --------+------------------------------------------------------------
// OCIOSO  | idle; waits for start, rejects bad word counts with erro
// RECEBE  | accepting bytes of the current word (byte_ready=1)
// ESCREVE | one-cycle write of the assembled word (we_mem=1)
// FIM     | load finished; done pulses on the following cycle
module i_mem_loader #(
    parameter int MEMORIA_TAMANHO = 256,
    parameter int CONT_W          = 9
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CONT_W-1:0] num_palavras,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              byte_ready,
    output logic              we_mem,
    output logic [31:0]       endereco_mem,
    output logic [31:0]       dado_mem,
    output logic              cpu_hold,
    output logic              done,
    output logic              erro
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        RECEBE  = 2'd1,
        ESCREVE = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam logic [CONT_W:0] MAX_PALAVRAS = (CONT_W+1)'(MEMORIA_TAMANHO);

    estado_t           estado;
    estado_t           prox_estado;
    logic [CONT_W-1:0] total_palavras;
    logic [CONT_W-1:0] cont_palavras;
    logic [1:0]        cont_bytes;
    logic              aceita;
    logic              start_ok;
    logic              ultima_palavra;

    assign aceita         = byte_valid && byte_ready;
    assign start_ok       = (num_palavras != '0) && ({1'b0, num_palavras} <= MAX_PALAVRAS);
    assign ultima_palavra = (cont_palavras + CONT_W'(1)) == total_palavras;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        byte_ready  = 1'b0;
        we_mem      = 1'b0;
        cpu_hold    = 1'b1;
        unique case (estado)
            OCIOSO: begin
                cpu_hold = 1'b0;
                if (start && start_ok) begin
                    prox_estado = RECEBE;
                end
            end
            RECEBE: begin
                byte_ready = 1'b1;
                if (aceita && (cont_bytes == 2'd3)) begin
                    prox_estado = ESCREVE;
                end
            end
            ESCREVE: begin
                we_mem      = 1'b1;
                prox_estado = ultima_palavra ? FIM : RECEBE;
            end
            FIM: begin
                prox_estado = OCIOSO;
            end
            default: begin
                prox_estado = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            total_palavras <= '0;
            cont_palavras  <= '0;
            cont_bytes     <= '0;
            endereco_mem   <= '0;
            dado_mem       <= '0;
            done           <= 1'b0;
            erro           <= 1'b0;
        end else begin
            erro <= (estado == OCIOSO) && start && !start_ok;
            done <= (estado == FIM);
            unique case (estado)
                OCIOSO: begin
                    if (start && start_ok) begin
                        total_palavras <= num_palavras;
                        cont_palavras  <= '0;
                        cont_bytes     <= '0;
                        endereco_mem   <= '0;
                        dado_mem       <= '0;
                    end
                end
                RECEBE: begin
                    // first byte of a word ends up in the top byte after four shifts
                    if (aceita) begin
                        dado_mem   <= {dado_mem[23:0], byte_in};
                        cont_bytes <= cont_bytes + 2'd1;
                    end
                end
                ESCREVE: begin
                    endereco_mem  <= endereco_mem + 32'd4;
                    cont_palavras <= cont_palavras + CONT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
